// File: rtl/afifo_wr_packer.sv
// Write-side packer ahead of afifo: gathers RATIO narrow beats into one wide word with a lane count.
// Optional idle auto-flush of partial words is enabled by defining AFIFO_WR_PACKER_TIMEOUT_EN.
module afifo_wr_packer #(
   parameter  int IN_W    = 8,
   parameter  int RATIO   = 4,
   parameter  int TIMEOUT = 16,
   localparam int OUT_W   = IN_W * RATIO,
   localparam int CW      = $clog2(RATIO)
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   input  logic             full_n,
   output logic             push,
   output logic [OUT_W-1:0] push_data,
   output logic [CW-1:0]    push_cnt,
   output logic             push_last
);

   if (RATIO < 2 || TIMEOUT < 1) begin : g_param_check
      $error("afifo_wr_packer: RATIO must be >= 2 and TIMEOUT >= 1");
   end

   logic [OUT_W-1:0] acc;
   logic [OUT_W-1:0] merged;
   logic [OUT_W-1:0] close_data;
   logic [CW-1:0]    lane_cnt;
   logic [CW-1:0]    close_cnt;
   logic             close_last;
   logic             accept;
   logic             close;
   logic             timeout_close;

   logic             out_vld;
   logic [OUT_W-1:0] out_data;
   logic [CW-1:0]    out_cnt;
   logic             out_last;

   // A word may only close when the holding register is empty or draining this cycle.
   assign in_rdy    = ~out_vld | full_n;
   assign push      = out_vld & full_n;
   assign accept    = in_vld & in_rdy;
   assign push_data = out_data;
   assign push_cnt  = out_cnt;
   assign push_last = out_last;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      merged = acc;
      for (int i = 0; i < RATIO; i++) begin
         if (lane_cnt == CW'(i)) merged[i*IN_W +: IN_W] = in_data;
      end
   end

`ifdef AFIFO_WR_PACKER_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT + 1);
   logic [IW-1:0] idle_cnt;

   assign timeout_close = ~accept & (lane_cnt != '0) & (idle_cnt == IW'(TIMEOUT - 1)) & in_rdy;

   // Saturates at TIMEOUT-1 so a flush blocked by full_n fires as soon as the FIFO has room.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         idle_cnt <= '0;
      end else if (accept || lane_cnt == '0 || timeout_close) begin
         idle_cnt <= '0;
      end else if (idle_cnt != IW'(TIMEOUT - 1)) begin
         idle_cnt <= idle_cnt + IW'(1);
      end
   end
`else
   assign timeout_close = 1'b0;
`endif

   assign close = (accept & ((lane_cnt == CW'(RATIO - 1)) | in_last)) | timeout_close;

   always_comb begin
      close_data = acc;
      close_cnt  = lane_cnt - CW'(1);
      close_last = 1'b0;
      if (accept) begin
         close_data = merged;
         close_cnt  = lane_cnt;
         close_last = in_last;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         acc      <= '0;
         lane_cnt <= '0;
         out_vld  <= 1'b0;
         out_data <= '0;
         out_cnt  <= '0;
         out_last <= 1'b0;
      end else begin
         if (close) begin
            acc      <= '0;
            lane_cnt <= '0;
         end else if (accept) begin
            acc      <= merged;
            lane_cnt <= lane_cnt + CW'(1);
         end

         if (close) begin
            out_vld  <= 1'b1;
            out_data <= close_data;
            out_cnt  <= close_cnt;
            out_last <= close_last;
         end else if (push) begin
            out_vld  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_afifo_wr_packer.sv
// Directed bench for afifo_wr_packer with a 4-deep FIFO occupancy model and a log of pushed words.
// Define AFIFO_WR_PACKER_TIMEOUT_EN for both files to exercise the idle flush.
module tb_afifo_wr_packer;
   localparam int IN_W    = 8;
   localparam int RATIO   = 4;
   localparam int TIMEOUT = 16;

   logic        wclk;
   logic        wrst_n;
   logic        in_vld;
   logic        in_rdy;
   logic [7:0]  in_data;
   logic        in_last;
   logic        full_n;
   logic        push;
   logic [31:0] push_data;
   logic [1:0]  push_cnt;
   logic        push_last;

   logic        fifo_mode;
   logic        full_n_drv;
   logic        pop_req;
   int          fcnt;
   int          nlog;
   int          viol;
   logic [34:0] plog [64];

   int          errors;
   int          checks;

   afifo_wr_packer #(.IN_W(IN_W), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .in_data   (in_data),
      .in_last   (in_last),
      .full_n    (full_n),
      .push      (push),
      .push_data (push_data),
      .push_cnt  (push_cnt),
      .push_last (push_last)
   );

   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   assign full_n = fifo_mode ? (fcnt < 4) : full_n_drv;

   always @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) fcnt <= 0;
      else if (fifo_mode) fcnt <= fcnt + (push ? 1 : 0) - ((pop_req && fcnt > 0) ? 1 : 0);
   end

   always @(posedge wclk) begin
      if (push) begin
         if (nlog < 64) plog[nlog] <= {push_last, push_cnt, push_data};
         nlog <= nlog + 1;
      end
      if (push && !full_n) viol <= viol + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l, output int waits);
      in_vld  = 1'b1;
      in_data = d;
      in_last = l;
      waits   = 0;
      while (!in_rdy && waits < 50) begin
         @(posedge wclk); #1;
         waits++;
      end
      if (!in_rdy) check("beat_rdy_timeout", 64'(in_rdy), 64'd1);
      @(posedge wclk); #1;
      in_vld  = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge wclk); #1;
   endtask

   initial begin
      int w;
      int wsum;
      int base;
      int found;
      logic [31:0] word;

      wrst_n = 1'b0; in_vld = 1'b0; in_data = '0; in_last = 1'b0;
      fifo_mode = 1'b0; full_n_drv = 1'b1; pop_req = 1'b0;
      #2;
      check("reset_push",    64'(push),      64'd0);
      check("reset_in_rdy",  64'(in_rdy),    64'd1);
      check("reset_word",    64'({push_last, push_cnt, push_data}), 64'd0);
      @(posedge wclk); @(posedge wclk); #1;
      wrst_n = 1'b1;
      idle_cycle();

      // Full word, back to back.
      wsum = 0;
      send_beat(8'h11, 1'b0, w); wsum += w;
      send_beat(8'h22, 1'b0, w); wsum += w;
      send_beat(8'h33, 1'b0, w); wsum += w;
      send_beat(8'h44, 1'b0, w); wsum += w;
      check("t1_no_stall", 64'(wsum), 64'd0);
      check("t1_push",     64'(push), 64'd1);
      check("t1_word",     64'({push_last, push_cnt, push_data}), {29'd0, 1'b0, 2'd3, 32'h44332211});
      idle_cycle();
      check("t1_drained",  64'(push), 64'd0);

      // Short packet, then a lane0 packet.
      send_beat(8'hAA, 1'b0, w);
      send_beat(8'hBB, 1'b1, w);
      check("t2_word",  64'({push, push_last, push_cnt, push_data}), {28'd0, 1'b1, 1'b1, 2'd1, 32'h0000BBAA});
      idle_cycle();
      send_beat(8'hCC, 1'b1, w);
      check("t2_lane0", 64'({push, push_last, push_cnt, push_data}), {28'd0, 1'b1, 1'b1, 2'd0, 32'h000000CC});
      idle_cycle();

      // Holding register under full_n=0.
      full_n_drv = 1'b0;
      send_beat(8'hA1, 1'b0, w);
      send_beat(8'hA2, 1'b0, w);
      send_beat(8'hA3, 1'b0, w);
      send_beat(8'hA4, 1'b0, w);
      in_vld = 1'b1; in_data = 8'hB1; in_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("t4_hold", 64'({push, in_rdy, push_last, push_cnt, push_data}),
               {27'd0, 1'b0, 1'b0, 1'b0, 2'd3, 32'hA4A3A2A1});
         idle_cycle();
      end
      full_n_drv = 1'b1;
      #1;
      check("t4_release", 64'({push, in_rdy}), 64'd3);
      send_beat(8'hB1, 1'b1, w);
      check("t4_push_and_close", 64'({push, push_last, push_cnt, push_data}),
            {28'd0, 1'b1, 1'b1, 2'd0, 32'h000000B1});
      idle_cycle();
      check("t4_drained", 64'(push), 64'd0);

      // Reset mid-word drops the partial accumulator.
      send_beat(8'hE1, 1'b0, w);
      send_beat(8'hE2, 1'b0, w);
      wrst_n = 1'b0;
      #1;
      check("t5_rst_state", 64'({push, in_rdy, dut.lane_cnt}), {61'd0, 1'b0, 1'b1, 2'd0});
      @(posedge wclk); #1;
      wrst_n = 1'b1;
      send_beat(8'h01, 1'b0, w);
      send_beat(8'h02, 1'b0, w);
      send_beat(8'h03, 1'b0, w);
      send_beat(8'h04, 1'b0, w);
      check("t5_word", 64'({push, push_last, push_cnt, push_data}), {28'd0, 1'b1, 1'b0, 2'd3, 32'h04030201});
      idle_cycle();

      // Stream into a 4-deep FIFO with no pops.
      wrst_n = 1'b0;
      @(posedge wclk); #1;
      fifo_mode = 1'b1;
      wrst_n = 1'b1;
      idle_cycle();
      base = nlog;
      wsum = 0;
      for (int i = 1; i <= 20; i++) begin
         send_beat(8'(8'h40 + i), 1'b0, w);
         wsum += w;
      end
      check("t3_no_stall", 64'(wsum), 64'd0);
      in_vld = 1'b1; in_data = 8'h55; in_last = 1'b0;
      idle_cycle(); idle_cycle(); idle_cycle();
      check("t3_full_hold", 64'({full_n, push, in_rdy, push_data}), {29'd0, 1'b0, 1'b0, 1'b0, 32'h54535251});
      check("t3_pushed4",   64'(nlog - base), 64'd4);
      pop_req = 1'b1;
      @(posedge wclk); #1;
      pop_req = 1'b0;
      check("t3_resume", 64'({push, in_rdy}), 64'd3);
      send_beat(8'h55, 1'b0, w);
      send_beat(8'h56, 1'b0, w);
      send_beat(8'h57, 1'b0, w);
      send_beat(8'h58, 1'b0, w);
      pop_req = 1'b1;
      repeat (8) @(posedge wclk);
      #1;
      pop_req = 1'b0;
      check("t3_pushed6", 64'(nlog - base), 64'd6);
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < 4; j++) word[j*8 +: 8] = 8'(8'h40 + 4*k + j + 1);
         check("t3_order", 64'(plog[base+k]), {29'd0, 1'b0, 2'd3, word});
      end
      check("t3_no_push_when_full", 64'(viol), 64'd0);
      fifo_mode = 1'b0;
      full_n_drv = 1'b1;
      idle_cycle();

      // Lone beat followed by idle cycles.
      send_beat(8'h5A, 1'b0, w);
      found = 0;
      for (int c = 1; c <= 40 && found == 0; c++) begin
         @(posedge wclk); #1;
         if (push) found = c;
      end
`ifdef AFIFO_WR_PACKER_TIMEOUT_EN
      check("t6_timeout_cycles", 64'(found), 64'd16);
      check("t6_word", 64'({push_last, push_cnt, push_data}), {29'd0, 1'b0, 2'd0, 32'h0000005A});
`else
      check("t6_no_push", 64'(found), 64'd0);
      check("t6_partial_kept", 64'(dut.lane_cnt), 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
